// File: rtl/axil_wr_slave.sv
// axil_wr_slave: AXI4-Lite write responder committing into a flat bank of 32-bit registers with byte strobes.
// Latency: register update and BVALID one edge after the later AW/W handshake; B handshake frees AW/W on that edge.
// Backpressure: AW/W ready drop after their handshake until the B handshake; BVALID/BRESP hold until BREADY. Option: AXIL_WR_DECERR_EN.
module axil_wr_slave #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 8,
  parameter int NUM_REGS         = 16
) (
  input  logic                                 AXI_ACLK,
  input  logic                                 AXI_ARESETN,
  input  logic [C_AXI_ADDR_WIDTH-1:0]          AXI_AWADDR,
  input  logic                                 AXI_AWVALID,
  output logic                                 AXI_AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]          AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]        AXI_WSTRB,
  input  logic                                 AXI_WVALID,
  output logic                                 AXI_WREADY,
  output logic [1:0]                           AXI_BRESP,
  output logic                                 AXI_BVALID,
  input  logic                                 AXI_BREADY,
  output logic [NUM_REGS*C_AXI_DATA_WIDTH-1:0] regs_out
);

  localparam int IDX_W  = C_AXI_ADDR_WIDTH - 2;
  localparam int STRB_W = C_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_WR_DECERR_EN
  localparam logic [1:0] RESP_ERR = 2'b11;
`else
  localparam logic [1:0] RESP_ERR = 2'b10;
`endif

  typedef enum logic [1:0] {IDLE, COMMIT, RESP} state_t;

  state_t                      state_q, state_d;
  logic                        aw_got_q, aw_got_d;
  logic                        w_got_q, w_got_d;
  logic                        awready_q, awready_d;
  logic                        wready_q, wready_d;
  logic                        bvalid_q, bvalid_d;
  logic [1:0]                  bresp_q, bresp_d;
  logic [IDX_W-1:0]            idx_q;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]           wstrb_q;
  logic [C_AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic aw_hs;
  logic w_hs;
  logic in_range;
  logic commit;

  // Byte offset within a word has no meaning for a word-wide register bank.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^AXI_AWADDR[1:0];

  assign aw_hs    = AXI_AWVALID & awready_q;
  assign w_hs     = AXI_WVALID & wready_q;
  assign in_range = (int'(idx_q) < NUM_REGS);
  assign commit   = (state_q == COMMIT) && in_range;

  assign AXI_AWREADY = awready_q;
  assign AXI_WREADY  = wready_q;
  assign AXI_BVALID  = bvalid_q;
  assign AXI_BRESP   = bresp_q;

  // Control state: FSM, handshake bookkeeping and registered channel outputs.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      state_q   <= IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Next-state: collect AW and W in any order, commit for one cycle, then hold B until accepted.
  always_comb begin
    state_d   = state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (state_q)
      IDLE: begin
        aw_got_d = aw_got_q | aw_hs;
        w_got_d  = w_got_q | w_hs;
        if (aw_got_d && w_got_d) begin
          state_d   = COMMIT;
          awready_d = 1'b0;
          wready_d  = 1'b0;
        end else begin
          awready_d = !aw_got_d;
          wready_d  = !w_got_d;
        end
      end
      COMMIT: begin
        state_d   = RESP;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b1;
        bresp_d   = in_range ? RESP_OKAY : RESP_ERR;
      end
      RESP: begin
        if (AXI_BREADY) begin
          state_d   = IDLE;
          bvalid_d  = 1'b0;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture address and data on their own handshakes; ready is low while a capture is held.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      if (aw_hs) idx_q <= AXI_AWADDR[C_AXI_ADDR_WIDTH-1:2];
      if (w_hs) begin
        wdata_q <= AXI_WDATA;
        wstrb_q <= AXI_WSTRB;
      end
    end
  end

  // Register bank: byte-masked write of the decoded register during COMMIT.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (commit && (int'(idx_q) == k)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wstrb_q[b]) regs_q[k][8*b +: 8] <= wdata_q[8*b +: 8];
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign regs_out[k*C_AXI_DATA_WIDTH +: C_AXI_DATA_WIDTH] = regs_q[k];
  end

endmodule

// File: tb/tb_axil_wr_slave.sv
// Bench for axil_wr_slave: reference register model plus a queue of expected write responses.
// Inputs change 1 time unit after the rising edge; outputs are read there too.
// Each scenario task checks its own results; a monitor counts B handshakes.
module tb_axil_wr_slave;
  localparam int NR = 16;
`ifdef AXIL_WR_DECERR_EN
  localparam logic [1:0] EXP_ERR = 2'b11;
`else
  localparam logic [1:0] EXP_ERR = 2'b10;
`endif

  logic           AXI_ACLK = 1'b0;
  logic           AXI_ARESETN;
  logic [7:0]     AXI_AWADDR;
  logic           AXI_AWVALID;
  logic           AXI_AWREADY;
  logic [31:0]    AXI_WDATA;
  logic [3:0]     AXI_WSTRB;
  logic           AXI_WVALID;
  logic           AXI_WREADY;
  logic [1:0]     AXI_BRESP;
  logic           AXI_BVALID;
  logic           AXI_BREADY;
  logic [NR*32-1:0] regs_out;

  always #5 AXI_ACLK = ~AXI_ACLK;

  axil_wr_slave #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(8), .NUM_REGS(NR)) dut (
    .AXI_ACLK(AXI_ACLK), .AXI_ARESETN(AXI_ARESETN),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
    .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .regs_out(regs_out)
  );

  int total_cnt = 0;
  int pass_cnt  = 0;
  int b_count   = 0;
  logic [31:0] model [NR];
  logic [1:0]  exp_q [$];

  // B handshake happens at the next rising edge whenever both are high at the falling edge.
  always @(negedge AXI_ACLK) if (AXI_ARESETN && AXI_BVALID && AXI_BREADY) b_count++;

  task automatic tick;
    @(posedge AXI_ACLK);
    #1;
  endtask

  function automatic logic [31:0] dut_reg(input int k);
    return regs_out[k*32 +: 32];
  endfunction

  function automatic logic [NR*32-1:0] model_flat();
    logic [NR*32-1:0] f;
    for (int k = 0; k < NR; k++) f[k*32 +: 32] = model[k];
    return f;
  endfunction

  task automatic model_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int k;
    k = int'(addr[7:2]);
    if (k < NR) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[k][8*b +: 8] = data[8*b +: 8];
      exp_q.push_back(2'b00);
    end else begin
      exp_q.push_back(EXP_ERR);
    end
  endtask

  task automatic send_aw(input logic [7:0] addr, output bit ok);
    bit hs;
    ok = 0;
    AXI_AWADDR  = addr;
    AXI_AWVALID = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      hs = AXI_AWREADY;
      tick;
      if (hs) ok = 1;
    end
    AXI_AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, output bit ok);
    bit hs;
    ok = 0;
    AXI_WDATA  = data;
    AXI_WSTRB  = strb;
    AXI_WVALID = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      hs = AXI_WREADY;
      tick;
      if (hs) ok = 1;
    end
    AXI_WVALID = 1'b0;
  endtask

  task automatic wait_b(input int stall, output logic [1:0] resp, output bit ok);
    int seen;
    seen = 0;
    ok   = 0;
    resp = 2'bxx;
    AXI_BREADY = (stall == 0);
    for (int i = 0; i < 300 && !ok; i++) begin
      if (AXI_BVALID) begin
        if (seen >= stall) AXI_BREADY = 1'b1;
        seen++;
      end
      if (AXI_BVALID && AXI_BREADY) begin
        resp = AXI_BRESP;
        ok   = 1;
      end
      tick;
    end
    AXI_BREADY = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int stall,
                          output logic [1:0] resp, output bit ok);
    bit ok_aw, ok_w, ok_b;
    fork
      begin repeat (aw_dly) tick; send_aw(addr, ok_aw); end
      begin repeat (w_dly) tick; send_w(data, strb, ok_w); end
    join
    wait_b(stall, resp, ok_b);
    ok = ok_aw & ok_w & ok_b;
  endtask

  task automatic test_reset;
    AXI_ARESETN = 1'b0;
    tick;
    tick;
    total_cnt++; if (AXI_AWREADY !== 1'b0) $display("FAIL reset_awready: got %b want 0", AXI_AWREADY); else pass_cnt++;
    total_cnt++; if (AXI_WREADY !== 1'b0) $display("FAIL reset_wready: got %b want 0", AXI_WREADY); else pass_cnt++;
    total_cnt++; if (AXI_BVALID !== 1'b0) $display("FAIL reset_bvalid: got %b want 0", AXI_BVALID); else pass_cnt++;
    total_cnt++; if (AXI_BRESP !== 2'b00) $display("FAIL reset_bresp: got %b want 00", AXI_BRESP); else pass_cnt++;
    total_cnt++; if (regs_out !== '0) $display("FAIL reset_regs: got %h want 0", regs_out); else pass_cnt++;
    AXI_ARESETN = 1'b1;
    tick;
    total_cnt++; if (AXI_AWREADY !== 1'b1) $display("FAIL reset_release_awready: got %b want 1", AXI_AWREADY); else pass_cnt++;
    total_cnt++; if (AXI_WREADY !== 1'b1) $display("FAIL reset_release_wready: got %b want 1", AXI_WREADY); else pass_cnt++;
  endtask

  task automatic test_same_edge;
    logic [1:0] exp;
    AXI_BREADY  = 1'b1;
    AXI_AWADDR  = 8'h08;
    AXI_AWVALID = 1'b1;
    AXI_WDATA   = 32'hDEADBEEF;
    AXI_WSTRB   = 4'hF;
    AXI_WVALID  = 1'b1;
    model_write(8'h08, 32'hDEADBEEF, 4'hF);
    tick;
    AXI_AWVALID = 1'b0;
    AXI_WVALID  = 1'b0;
    total_cnt++; if (AXI_AWREADY !== 1'b0) $display("FAIL same_edge_awready_low: got %b want 0", AXI_AWREADY); else pass_cnt++;
    total_cnt++; if (AXI_WREADY !== 1'b0) $display("FAIL same_edge_wready_low: got %b want 0", AXI_WREADY); else pass_cnt++;
    total_cnt++; if (AXI_BVALID !== 1'b0) $display("FAIL same_edge_bvalid_early: got %b want 0", AXI_BVALID); else pass_cnt++;
    tick;
    exp = exp_q.pop_front();
    total_cnt++; if (dut_reg(2) !== 32'hDEADBEEF) $display("FAIL same_edge_reg2: got %h want deadbeef", dut_reg(2)); else pass_cnt++;
    total_cnt++; if (AXI_BVALID !== 1'b1) $display("FAIL same_edge_bvalid: got %b want 1", AXI_BVALID); else pass_cnt++;
    total_cnt++; if (AXI_BRESP !== exp) $display("FAIL same_edge_bresp: got %b want %b", AXI_BRESP, exp); else pass_cnt++;
    tick;
    AXI_BREADY = 1'b0;
    total_cnt++; if (AXI_BVALID !== 1'b0) $display("FAIL same_edge_bvalid_drop: got %b want 0", AXI_BVALID); else pass_cnt++;
    total_cnt++; if (AXI_AWREADY !== 1'b1) $display("FAIL same_edge_awready_back: got %b want 1", AXI_AWREADY); else pass_cnt++;
    total_cnt++; if (AXI_WREADY !== 1'b1) $display("FAIL same_edge_wready_back: got %b want 1", AXI_WREADY); else pass_cnt++;
  endtask

  task automatic test_w_first;
    logic [1:0] resp, exp;
    bit ok;
    model_write(8'h04, 32'hFFFFFFFF, 4'hF);
    do_write(8'h04, 32'hFFFFFFFF, 4'hF, 0, 0, 0, resp, ok);
    exp = exp_q.pop_front();
    total_cnt++; if (!ok) $display("FAIL w_first_prefill_timeout: got timeout want response"); else pass_cnt++;
    total_cnt++; if (resp !== exp) $display("FAIL w_first_prefill_bresp: got %b want %b", resp, exp); else pass_cnt++;
    model_write(8'h04, 32'h12345678, 4'b0101);
    AXI_WDATA  = 32'h12345678;
    AXI_WSTRB  = 4'b0101;
    AXI_WVALID = 1'b1;
    tick;
    AXI_WVALID = 1'b0;
    total_cnt++; if (AXI_WREADY !== 1'b0) $display("FAIL w_first_wready_low: got %b want 0", AXI_WREADY); else pass_cnt++;
    total_cnt++; if (AXI_AWREADY !== 1'b1) $display("FAIL w_first_awready_high: got %b want 1", AXI_AWREADY); else pass_cnt++;
    tick;
    tick;
    total_cnt++; if (AXI_WREADY !== 1'b0) $display("FAIL w_first_wready_hold: got %b want 0", AXI_WREADY); else pass_cnt++;
    send_aw(8'h04, ok);
    total_cnt++; if (!ok) $display("FAIL w_first_aw_timeout: got timeout want handshake"); else pass_cnt++;
    wait_b(0, resp, ok);
    exp = exp_q.pop_front();
    total_cnt++; if (!ok) $display("FAIL w_first_b_timeout: got timeout want response"); else pass_cnt++;
    total_cnt++; if (resp !== exp) $display("FAIL w_first_bresp: got %b want %b", resp, exp); else pass_cnt++;
    total_cnt++; if (dut_reg(1) !== 32'hFF34FF78) $display("FAIL w_first_reg1: got %h want ff34ff78", dut_reg(1)); else pass_cnt++;
  endtask

  task automatic test_out_of_range;
    logic [1:0] resp, exp;
    bit ok;
    model_write(8'h40, 32'hAAAAAAAA, 4'hF);
    do_write(8'h40, 32'hAAAAAAAA, 4'hF, 1, 0, 2, resp, ok);
    exp = exp_q.pop_front();
    total_cnt++; if (!ok) $display("FAIL oor_timeout: got timeout want response"); else pass_cnt++;
    total_cnt++; if (resp !== exp) $display("FAIL oor_bresp: got %b want %b", resp, exp); else pass_cnt++;
    total_cnt++; if (regs_out !== model_flat()) $display("FAIL oor_regs: got %h want %h", regs_out, model_flat()); else pass_cnt++;
    // Low address bits are ignored: 0x0B targets register 2.
    model_write(8'h0B, 32'h55AA1234, 4'b0100);
    do_write(8'h0B, 32'h55AA1234, 4'b0100, 0, 1, 1, resp, ok);
    exp = exp_q.pop_front();
    total_cnt++; if (!ok) $display("FAIL lsb_timeout: got timeout want response"); else pass_cnt++;
    total_cnt++; if (resp !== exp) $display("FAIL lsb_bresp: got %b want %b", resp, exp); else pass_cnt++;
    total_cnt++; if (dut_reg(2) !== 32'hDEAABEEF) $display("FAIL lsb_reg2: got %h want deaabeef", dut_reg(2)); else pass_cnt++;
    model_write(8'h0C, 32'hFFFFFFFF, 4'b0000);
    do_write(8'h0C, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, resp, ok);
    exp = exp_q.pop_front();
    total_cnt++; if (!ok) $display("FAIL zero_strb_timeout: got timeout want response"); else pass_cnt++;
    total_cnt++; if (resp !== exp) $display("FAIL zero_strb_bresp: got %b want %b", resp, exp); else pass_cnt++;
    total_cnt++; if (regs_out !== model_flat()) $display("FAIL zero_strb_regs: got %h want %h", regs_out, model_flat()); else pass_cnt++;
  endtask

  task automatic test_bready_stall;
    logic [1:0] resp, exp;
    bit ok, ok_aw, ok_w;
    model_write(8'h14, 32'hCAFEF00D, 4'hF);
    fork
      send_aw(8'h14, ok_aw);
      send_w(32'hCAFEF00D, 4'hF, ok_w);
    join
    for (int i = 0; i < 10 && !AXI_BVALID; i++) tick;
    total_cnt++; if (AXI_BVALID !== 1'b1) $display("FAIL stall_bvalid_rise: got %b want 1", AXI_BVALID); else pass_cnt++;
    exp = exp_q.pop_front();
    AXI_AWADDR  = 8'h18;
    AXI_AWVALID = 1'b1;
    AXI_WDATA   = 32'h0BADC0DE;
    AXI_WSTRB   = 4'hF;
    AXI_WVALID  = 1'b1;
    AXI_BREADY  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      total_cnt++; if (AXI_BVALID !== 1'b1) $display("FAIL stall_bvalid c%0d: got %b want 1", c, AXI_BVALID); else pass_cnt++;
      total_cnt++; if (AXI_BRESP !== exp) $display("FAIL stall_bresp c%0d: got %b want %b", c, AXI_BRESP, exp); else pass_cnt++;
      total_cnt++; if (AXI_AWREADY !== 1'b0) $display("FAIL stall_awready c%0d: got %b want 0", c, AXI_AWREADY); else pass_cnt++;
      total_cnt++; if (AXI_WREADY !== 1'b0) $display("FAIL stall_wready c%0d: got %b want 0", c, AXI_WREADY); else pass_cnt++;
      tick;
    end
    AXI_BREADY = 1'b1;
    tick;
    AXI_BREADY = 1'b0;
    total_cnt++; if (AXI_BVALID !== 1'b0) $display("FAIL stall_bvalid_drop: got %b want 0", AXI_BVALID); else pass_cnt++;
    total_cnt++; if (AXI_AWREADY !== 1'b1) $display("FAIL stall_awready_back: got %b want 1", AXI_AWREADY); else pass_cnt++;
    total_cnt++; if (AXI_WREADY !== 1'b1) $display("FAIL stall_wready_back: got %b want 1", AXI_WREADY); else pass_cnt++;
    model_write(8'h18, 32'h0BADC0DE, 4'hF);
    tick;
    AXI_AWVALID = 1'b0;
    AXI_WVALID  = 1'b0;
    total_cnt++; if (AXI_AWREADY !== 1'b0) $display("FAIL stall_next_aw_taken: got awready %b want 0", AXI_AWREADY); else pass_cnt++;
    total_cnt++; if (AXI_WREADY !== 1'b0) $display("FAIL stall_next_w_taken: got wready %b want 0", AXI_WREADY); else pass_cnt++;
    wait_b(0, resp, ok);
    exp = exp_q.pop_front();
    total_cnt++; if (!ok) $display("FAIL stall_next_timeout: got timeout want response"); else pass_cnt++;
    total_cnt++; if (resp !== exp) $display("FAIL stall_next_bresp: got %b want %b", resp, exp); else pass_cnt++;
    total_cnt++; if (dut_reg(6) !== 32'h0BADC0DE) $display("FAIL stall_next_reg6: got %h want 0badc0de", dut_reg(6)); else pass_cnt++;
  endtask

  task automatic test_reset_in_resp;
    bit ok_aw, ok_w;
    model_write(8'h0C, 32'h33333333, 4'hF);
    AXI_BREADY = 1'b0;
    fork
      send_aw(8'h0C, ok_aw);
      send_w(32'h33333333, 4'hF, ok_w);
    join
    for (int i = 0; i < 10 && !AXI_BVALID; i++) tick;
    total_cnt++; if (dut_reg(3) !== 32'h33333333) $display("FAIL rst_resp_reg3: got %h want 33333333", dut_reg(3)); else pass_cnt++;
    AXI_ARESETN = 1'b0;
    #1;
    total_cnt++; if (AXI_BVALID !== 1'b0) $display("FAIL rst_resp_bvalid: got %b want 0", AXI_BVALID); else pass_cnt++;
    total_cnt++; if (regs_out !== '0) $display("FAIL rst_resp_regs: got %h want 0", regs_out); else pass_cnt++;
    total_cnt++; if (AXI_AWREADY !== 1'b0) $display("FAIL rst_resp_awready: got %b want 0", AXI_AWREADY); else pass_cnt++;
    for (int k = 0; k < NR; k++) model[k] = '0;
    exp_q.delete();
    tick;
    tick;
    AXI_ARESETN = 1'b1;
    tick;
    total_cnt++; if (AXI_AWREADY !== 1'b1) $display("FAIL rst_resp_release_awready: got %b want 1", AXI_AWREADY); else pass_cnt++;
    total_cnt++; if (AXI_WREADY !== 1'b1) $display("FAIL rst_resp_release_wready: got %b want 1", AXI_WREADY); else pass_cnt++;
    AXI_BREADY = 1'b1;
    for (int c = 0; c < 5; c++) begin
      total_cnt++; if (AXI_BVALID !== 1'b0) $display("FAIL rst_resp_stale_b c%0d: got %b want 0", c, AXI_BVALID); else pass_cnt++;
      tick;
    end
    AXI_BREADY = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [1:0]  resp, exp;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    bit ok;
    int start, n;
    start = b_count;
    n = 48;
    for (int i = 0; i < n; i++) begin
      addr = 8'((i % NR) * 4);
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      model_write(addr, data, strb);
      do_write(addr, data, strb, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3), resp, ok);
      exp = exp_q.pop_front();
      total_cnt++; if (!ok) $display("FAIL b2b_timeout #%0d: got timeout want response", i); else pass_cnt++;
      total_cnt++; if (resp !== exp) $display("FAIL b2b_bresp #%0d: got %b want %b", i, resp, exp); else pass_cnt++;
    end
    total_cnt++; if (regs_out !== model_flat()) $display("FAIL b2b_regs: got %h want %h", regs_out, model_flat()); else pass_cnt++;
    total_cnt++; if ((b_count - start) !== n) $display("FAIL b2b_b_count: got %0d want %0d", b_count - start, n); else pass_cnt++;
    tick;
    tick;
    total_cnt++; if (AXI_BVALID !== 1'b0) $display("FAIL b2b_no_extra_b: got %b want 0", AXI_BVALID); else pass_cnt++;
  endtask

  initial begin
    AXI_ARESETN = 1'b0;
    AXI_AWADDR  = '0;
    AXI_AWVALID = 1'b0;
    AXI_WDATA   = '0;
    AXI_WSTRB   = '0;
    AXI_WVALID  = 1'b0;
    AXI_BREADY  = 1'b0;
    for (int k = 0; k < NR; k++) model[k] = '0;
    test_reset;
    test_same_edge;
    test_w_first;
    test_out_of_range;
    test_bready_stall;
    test_reset_in_resp;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/axil_wr_slave.md
# axil_wr_slave

AXI4-Lite write-channel responder: accepts write addresses (AW) and write data (W) in either order, commits the write into an internal bank of 32-bit registers with byte strobes, and returns a write response (B). It is the slave-side counterpart of the master write-address checker interface and sits behind the AXI-Lite interconnect as the register target of a peripheral. The register bank is exported flat for use by the peripheral core.

## Interface
- C_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_AXI_ADDR_WIDTH, 8, byte address width.
- NUM_REGS, 16, number of 32-bit registers; must be ≤ 2^(C_AXI_ADDR_WIDTH-2).

Ports:
- AXI_ACLK  in  1  clock; all logic on its rising edge.
- AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
- AXI_AWADDR  in  C_AXI_ADDR_WIDTH  write byte address.
- AXI_AWVALID  in  1  address valid.
- AXI_AWREADY  out  1  address ready.
- AXI_WDATA  in  32  write data.
- AXI_WSTRB  in  4  byte enables; bit i enables WDATA[8i+7:8i].
- AXI_WVALID  in  1  data valid.
- AXI_WREADY  out  1  data ready.
- AXI_BRESP  out  2  response: 2'b00 OKAY, 2'b10 SLVERR, 2'b11 DECERR.
- AXI_BVALID  out  1  response valid.
- AXI_BREADY  in  1  response ready.
- regs_out  out  NUM_REGS*32  register bank; register k at [32k+31:32k].

## Operation
- States: IDLE, COMMIT, RESP.
- IDLE: AWREADY = !aw_got, WREADY = !w_got (both registered). AW handshake (AWVALID & AWREADY at an edge) latches AWADDR, sets aw_got. W handshake latches WDATA/WSTRB, sets w_got. The two may occur on the same edge or in either order, any number of cycles apart.
- When aw_got & w_got: go to COMMIT; AWREADY = WREADY = 0.
- COMMIT (exactly one cycle): decode index = addr[C_AXI_ADDR_WIDTH-1:2]; addr[1:0] ignored. If index < NUM_REGS, write enabled bytes into register index, BRESP = OKAY. Otherwise no register changes, BRESP = SLVERR (see Configuration). WSTRB = 4'b0000 to a valid index is OKAY with no change.
- RESP: BVALID = 1, BRESP stable until BVALID & BREADY at an edge; at that edge BVALID = 0, aw_got = w_got = 0, AWREADY = WREADY = 1, state IDLE.
- One transaction outstanding at a time; no new AW or W is accepted in COMMIT or RESP.
- Reset (ARESETN low, any state): asynchronously AWREADY = 0, WREADY = 0, BVALID = 0, BRESP = 2'b00, all registers and regs_out = 0, aw_got = w_got = 0, state IDLE. A pending transaction is dropped without a response.

## Timing
- First edge with ARESETN high: AWREADY and WREADY go to 1.
- Last of the AW/W handshakes at edge N: COMMIT during cycle N→N+1; at edge N+1 the register (regs_out) updates, BVALID = 1 and BRESP becomes valid.
- BREADY high already when BVALID rises: handshake at edge N+2; AWREADY/WREADY are 1 after edge N+2. Next transaction's earliest AW handshake is edge N+3.
- AWREADY stays low from the edge after its handshake until the B handshake, so no AW is ever lost. The same holds for W.
- AWVALID deasserted while AWREADY is low has no effect. Master-side stability is not checked here.

## Configuration
- AXIL_WR_DECERR_EN: when defined, an out-of-range index returns BRESP = 2'b11 (DECERR). When undefined, it returns 2'b10 (SLVERR). In both cases no register is written. In-range behaviour is identical.

## Test plan
- Reset, then AW 0x08 and W 0xDEADBEEF with strb 4'hF on the same edge, BREADY held 1 -> regs_out reg 2 = 0xDEADBEEF at the next edge; BVALID 1 for one cycle with BRESP 00; AWREADY/WREADY 1 after.
- W 0x12345678 with strb 4'b0101 first, AW 0x04 three cycles later, over reg 1 = 0xFFFFFFFF -> WREADY low after the W handshake; reg 1 = 0xFF34FF78; BRESP 00.
- AW 0x40 (index 16 with NUM_REGS = 16), W 0xAAAAAAAA -> no register change; BRESP 10 without the macro, 11 with AXIL_WR_DECERR_EN.
- BREADY held low for 10 cycles after BVALID, with a new AWVALID/WVALID pending -> BVALID and BRESP stable, AWREADY/WREADY 0 throughout; the new AW/W is accepted on the edge after the B handshake.
- ARESETN pulsed low during RESP after reg 3 was written -> BVALID drops immediately; regs_out = 0; after release, AWREADY = WREADY = 1 on the first edge and no stale response appears.
- Back-to-back writes to all 16 registers with random strobes and random BREADY stalls -> regs_out matches the byte-masked reference model and each transaction has exactly one B response.
